// File: rtl/dmem_port.sv
// dmem_port: wait-stated single-port data memory for a load/store unit.
// Optional misalignment trap: define DMEM_MISALIGN_TRAP_EN to flag and suppress misaligned accesses.
module dmem_port #(
  parameter int ADDR_WORDS  = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [3:0]  we,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        busy,
  output logic        fault
);
  localparam int AW = $clog2(ADDR_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t        r_state, w_next;
  logic [3:0]    r_cnt, r_we;
  logic [AW-1:0] r_idx;
  logic [31:0]   r_wdata, r_rdata;
  logic          r_ack;
  logic [31:0]   r_mem [ADDR_WORDS];
  logic          w_accept, w_access, w_mis;

  assign w_accept = (r_state == IDLE) && req;
  assign w_access = (r_state == WAIT) && (r_cnt == 4'd0);
  assign rdata    = r_rdata;
  assign ack      = r_ack;
  assign busy     = (r_state != IDLE);

`ifdef DMEM_MISALIGN_TRAP_EN
  logic [1:0] r_size, r_lo;
  logic       r_fault;
  logic       w_unused;
  assign w_unused = ^addr[31:AW+2];
  assign w_mis    = ((r_size == 2'b01) && r_lo[0]) || (r_size[1] && (r_lo != 2'b00));
  assign fault    = r_fault;
  // Capture alignment info at acceptance; fault is registered alongside ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_size  <= 2'b00;
      r_lo    <= 2'b00;
      r_fault <= 1'b0;
    end else begin
      r_fault <= (r_state == DONE) && w_mis;
      if (w_accept) begin
        r_size <= size;
        r_lo   <= addr[1:0];
      end
    end
  end
`else
  logic w_unused;
  assign w_unused = ^{size, addr[1:0], addr[31:AW+2]};
  assign w_mis    = 1'b0;
  assign fault    = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  end

  // Next state: accept in IDLE, count down in WAIT, DONE always returns to IDLE
  always_comb begin
    w_next = (r_state == IDLE) ? (req ? WAIT : IDLE) :
             (r_state == WAIT) ? ((r_cnt == 4'd0) ? DONE : WAIT) : IDLE;
  end

  // Request latch, wait counter, read data and the ack pulse leaving DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= 4'd0;
      r_we    <= 4'd0;
      r_idx   <= '0;
      r_wdata <= 32'h0;
      r_rdata <= 32'h0;
      r_ack   <= 1'b0;
    end else begin
      r_ack <= (r_state == DONE);
      if (w_accept) begin
        r_cnt   <= 4'(WAIT_STATES);
        r_we    <= we;
        r_idx   <= addr[AW+1:2];
        r_wdata <= wdata;
      end else if ((r_state == WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_access && !w_mis && (r_we == 4'd0)) r_rdata <= r_mem[r_idx];
    end
  end

  // Array contents survive reset; only enabled byte lanes are written
  always_ff @(posedge clk) begin
    if (w_access && !w_mis) begin
      for (int b = 0; b < 4; b++) begin
        if (r_we[b]) r_mem[r_idx][8*b +: 8] <= r_wdata[8*b +: 8];
      end
    end
  end
endmodule

// File: tb/tb_dmem_port.sv
// tb_dmem_port: directed bench with a transaction-level memory model checked every cycle.
module tb_dmem_port;
  localparam int WS = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic [3:0]  we = 4'h0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        ack, busy, fault;

  dmem_port #(.ADDR_WORDS(1024), .WAIT_STATES(WS)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size), .addr(addr),
    .wdata(wdata), .rdata(rdata), .ack(ack), .busy(busy), .fault(fault)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          acc;
    logic [3:0]  we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t        q[$];
  logic [31:0] mem [1024];
  logic [31:0] exp_rdata = 32'h0;
  int          ack_cyc[$];

  function automatic bit misal(logic [1:0] s, logic [31:0] a);
`ifdef DMEM_MISALIGN_TRAP_EN
    return ((s == 2'b01) && a[0]) || (s[1] && (a[1:0] != 2'b00));
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Model: access lands WS+1 edges after acceptance, ack one edge later, busy in between
  logic e_busy, e_ack, e_fault;
  int   w;
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      exp_rdata = 32'h0;
    end
    e_busy = 1'b0;
    e_ack = 1'b0;
    e_fault = 1'b0;
    foreach (q[i]) begin
      if (cyc >= q[i].acc && cyc <= q[i].acc + WS + 1) e_busy = 1'b1;
      if (cyc == q[i].acc + WS + 1 && !misal(q[i].size, q[i].addr)) begin
        w = int'(q[i].addr[11:2]);
        if (q[i].we == 4'h0) exp_rdata = mem[w];
        else for (int b = 0; b < 4; b++) if (q[i].we[b]) mem[w][8*b +: 8] = q[i].wdata[8*b +: 8];
      end
      if (cyc == q[i].acc + WS + 2) begin
        e_ack = 1'b1;
        e_fault = misal(q[i].size, q[i].addr);
      end
    end
    while (q.size() > 0 && cyc > q[0].acc + WS + 2) void'(q.pop_front());
    if (ack === 1'b1) ack_cyc.push_back(cyc);
    chk("busy", {31'h0, busy}, {31'h0, e_busy});
    chk("ack", {31'h0, ack}, {31'h0, e_ack});
    chk("fault", {31'h0, fault}, {31'h0, e_fault});
    chk("rdata", rdata, exp_rdata);
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(logic [3:0] w_, logic [1:0] s, logic [31:0] a, logic [31:0] d);
    req = 1'b1; we = w_; size = s; addr = a; wdata = d;
    q.push_back('{cyc + 1, w_, s, a, d});
  endtask

  // Single access; returns just after the ack edge, with the DUT back in IDLE
  task automatic access(logic [3:0] w_, logic [1:0] s, logic [31:0] a, logic [31:0] d);
    issue(w_, s, a, d);
    tick(1);
    req = 1'b0;
    tick(WS + 2);
    chk("ack_latency", {31'h0, ack}, 32'h1);
  endtask

  int acc1;
  int n;

  initial begin
    tick(2);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_ack", {31'h0, ack}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_fault", {31'h0, fault}, 32'h0);
    rst_n = 1'b1;
    tick(1);

    access(4'hF, 2'b10, 32'h10, 32'hDEADBEEF);
    chk("wr_keeps_rdata", rdata, 32'h0);
    access(4'h0, 2'b10, 32'h10, 32'h0);
    chk("rd_deadbeef", rdata, 32'hDEADBEEF);

    access(4'hF, 2'b10, 32'h10, 32'h11223344);
    access(4'h4, 2'b00, 32'h12, 32'h55555555);
    access(4'h0, 2'b10, 32'h10, 32'h0);
    chk("rd_lane_merge", rdata, 32'h11553344);

    access(4'hF, 2'b10, 32'h1000, 32'hCAFEF00D);
    access(4'h0, 2'b10, 32'h0, 32'h0);
    chk("rd_wrap", rdata, 32'hCAFEF00D);

    access(4'hF, 2'b10, 32'h30, 32'hA5A5A5A5);
    n = ack_cyc.size();
    acc1 = cyc + 1;
    issue(4'h0, 2'b10, 32'h10, 32'h0);
    tick(1);
    addr = 32'h30;
    q.push_back('{acc1 + WS + 3, 4'h0, 2'b10, 32'h30, 32'h0});
    tick(WS + 2);
    chk("held_rd1", rdata, 32'h11553344);
    chk("held_gap_busy", {31'h0, busy}, 32'h0);
    tick(1);
    chk("held_reaccept_busy", {31'h0, busy}, 32'h1);
    req = 1'b0;
    tick(WS + 2);
    chk("held_rd2", rdata, 32'hA5A5A5A5);
    chk("held_ack_count", ack_cyc.size() - n, 32'd2);
    if (ack_cyc.size() - n == 2) chk("held_ack_spacing", ack_cyc[n+1] - ack_cyc[n], 32'd5);

    access(4'hF, 2'b10, 32'h20, 32'h12345678);
    issue(4'hF, 2'b10, 32'h20, 32'hBAD0BAD0);
    tick(1);
    req = 1'b0;
    tick(1);
    chk("abort_in_wait", {31'h0, busy}, 32'h1);
    rst_n = 1'b0;
    tick(1);
    chk("abort_rst_busy", {31'h0, busy}, 32'h0);
    rst_n = 1'b1;
    tick(4);
    chk("abort_no_ack", {31'h0, ack}, 32'h0);
    access(4'h0, 2'b10, 32'h20, 32'h0);
    chk("abort_rd", rdata, 32'h12345678);

    access(4'hF, 2'b10, 32'h22, 32'hFFFFFFFF);
`ifdef DMEM_MISALIGN_TRAP_EN
    chk("mis_fault", {31'h0, fault}, 32'h1);
`else
    chk("mis_fault", {31'h0, fault}, 32'h0);
`endif
    access(4'h0, 2'b10, 32'h20, 32'h0);
`ifdef DMEM_MISALIGN_TRAP_EN
    chk("mis_rd", rdata, 32'h12345678);
`else
    chk("mis_rd", rdata, 32'hFFFFFFFF);
`endif
    access(4'h0, 2'b01, 32'h11, 32'h0);
    access(4'h0, 2'b00, 32'h13, 32'h0);
    chk("byte_rd_full_word", rdata, 32'h11553344);

    tick(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dmem_port.md
DMEM_PORT -- requirements
Module: dmem_port

Interface
REQ-001 SHALL have parameter ADDR_WORDS, default 1024, meaning the number of 32-bit words in the internal data array (power of two).
REQ-002 SHALL have parameter WAIT_STATES, default 2, meaning the extra cycles inserted before each access completes (0..15).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port req, input, 1 bit: access request level from the load/store controller.
REQ-006 SHALL have port we, input, 4 bits: byte-lane write enables; 4'b0000 means read.
REQ-007 SHALL have port size, input, 2 bits: access size, 00 byte, 01 halfword, 10 word, 11 treated as word.
REQ-008 SHALL have port addr, input, 32 bits: byte address.
REQ-009 SHALL have port wdata, input, 32 bits: lane-replicated write data.
REQ-010 SHALL have port rdata, output, 32 bits: full word read, unextended; lane selection and sign extension are done downstream.
REQ-011 SHALL have port ack, output, 1 bit: one-cycle completion pulse.
REQ-012 SHALL have port busy, output, 1 bit: high whenever the FSM is not IDLE.
REQ-013 SHALL have port fault, output, 1 bit: misalignment flag, pulsed with ack.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, DONE.
REQ-015 In IDLE with req=1 at a rising edge, SHALL latch we, size, addr, wdata, load wait counter with WAIT_STATES, and go to WAIT; later input changes are ignored until the next acceptance.
REQ-016 In WAIT, SHALL decrement the counter each cycle; at counter 0, SHALL perform the access on that edge and go to DONE.
REQ-017 SHALL, with WAIT_STATES=0, spend exactly one cycle in WAIT, so ack rises WAIT_STATES+2 cycles after the accepting edge.
REQ-018 In DONE, SHALL assert ack for exactly one cycle and return to IDLE unconditionally; req high during DONE SHALL NOT be accepted.
REQ-019 SHALL allow a held req to start a new access in the IDLE cycle after DONE: minimum request spacing of WAIT_STATES+3 cycles.
REQ-020 SHALL index the array with word index addr[log2(ADDR_WORDS)+1:2]; upper address bits are ignored, so addresses wrap modulo 4*ADDR_WORDS.
REQ-021 On a write, SHALL update only the byte lanes whose we bit is set; rdata SHALL remain unchanged.
REQ-022 On a read, SHALL load rdata with the indexed word; rdata SHALL hold until the next completed read.
REQ-023 SHALL drive busy=1 in WAIT and DONE, and 0 in IDLE.

Reset
REQ-024 SHALL, on rst_n low, asynchronously force state IDLE, counter 0, rdata 32'h0, ack 0, busy 0, fault 0.
REQ-025 SHALL discard an in-flight access on reset; a write in WAIT SHALL NOT reach the array.
REQ-026 SHALL NOT reset array contents.

Configuration
REQ-027 Macro DMEM_MISALIGN_TRAP_EN defined: SHALL flag an access as misaligned when size=01 with addr[0]=1, or size=10/11 with addr[1:0]!=0.
REQ-028 Under DMEM_MISALIGN_TRAP_EN, a misaligned access SHALL leave the array and rdata unchanged and SHALL pulse fault together with ack.
REQ-029 Macro DMEM_MISALIGN_TRAP_EN undefined: fault SHALL be tied 0 and every access SHALL proceed per REQ-020..022.

Verification
REQ-030 Reset, then write we=1111 addr=0x10 wdata=0xDEADBEEF, then read addr=0x10 -> each ack 4 cycles after acceptance; rdata=0xDEADBEEF.
REQ-031 Write we=0100 wdata=0x55555555 to addr 0x12 over word 0x11223344 -> read returns 0x11553344.
REQ-032 With ADDR_WORDS=1024, write 0xCAFEF00D to addr 0x1000 -> read of addr 0x0 returns 0xCAFEF00D (wrap-around).
REQ-033 Hold req high across two reads -> acks exactly WAIT_STATES+3=5 cycles apart; busy low for exactly one cycle between them.
REQ-034 Assert rst_n low in WAIT of a write to addr 0x20 -> ack never pulses; subsequent read of 0x20 returns the prior value.
REQ-035 With DMEM_MISALIGN_TRAP_EN, word write to addr 0x22 -> ack and fault pulse together; word 0x20 is unchanged. Without the macro, fault stays 0.
